// File: rtl/pc_gen_ras.sv
// Fetch-PC generator with a return-address stack: picks the next IF PC from
// reset, EX redirect, stall/hold, RAS return, predicted target or sequential step.
module pc_gen_ras #(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR    = '0,
    parameter int                RAS_DEPTH     = 4,
    parameter int                HOLD_W        = 3,
    parameter logic [HOLD_W-1:0] HOLD_PC_LVL   = HOLD_W'(1),
    parameter bit                C_EXT         = 1'b1,
    parameter bit                RAS_FLUSH_JMP = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           jtag_reset_i,
    input  logic                           jump_flag_i,
    input  logic [ADDR_W-1:0]              jump_addr_i,
    input  logic [HOLD_W-1:0]              hold_flag_i,
    input  logic                           stall_i,
    input  logic                           prdt_taken_i,
    input  logic [ADDR_W-1:0]              prdt_addr_i,
    input  logic                           prdt_is_call_i,
    input  logic                           prdt_is_ret_i,
    input  logic                           inst_is_rvc_i,
    output logic [ADDR_W-1:0]              pc_o,
    output logic [ADDR_W-1:0]              ras_top_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_o,
    output logic                           ras_ovf_o
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              rst_any;
    logic              hold;
    logic              adv;
    logic              ras_nonempty;
    logic              ras_full;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] ras_top;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign rst_any      = rst | jtag_reset_i;
    assign hold         = (hold_flag_i >= HOLD_PC_LVL);
    assign adv          = !rst_any && !jump_flag_i && !stall_i && !hold;
    assign ras_nonempty = (cnt_q != '0);
    assign ras_full     = (cnt_q == CNT_W'(RAS_DEPTH));
    // Write pointer points one past the newest entry; wraps modulo depth.
    assign top_idx      = ptr_q - PTR_W'(1);
    assign step         = (C_EXT && inst_is_rvc_i) ? ADDR_W'(2) : ADDR_W'(4);
    assign ret_addr     = pc_q + step;
    assign ras_top      = ras_nonempty ? ras_q[top_idx] : '0;

    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (jump_flag_i) begin
            pc_d = jump_addr_i;
            if (RAS_FLUSH_JMP) begin
                cnt_d = '0;
                ptr_d = '0;
            end
        end else if (adv) begin
            if (prdt_is_ret_i && ras_nonempty) begin
                pc_d = ras_top;
                if (prdt_is_call_i) begin
                    // Call and return together: replace the top in place.
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                pc_d = prdt_taken_i ? prdt_addr_i : ret_addr;
                if (prdt_is_call_i) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (ras_full) ovf_d = 1'b1;
                    else          cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            pc_q  <= RESET_ADDR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) ras_q[wr_idx] <= ret_addr;
    end

    assign pc_o        = pc_q;
    assign ras_top_o   = ras_top;
    assign ras_count_o = cnt_q;
    assign ras_ovf_o   = ovf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: two instances (C_EXT=1 and C_EXT=0) checked every cycle
// against a list-based return-stack model, plus directed literal expectations.
module tb_pc_gen_ras;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jtag_reset_i = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [2:0]  hold_flag_i = '0;
    logic        stall_i = 1'b0;
    logic        prdt_taken_i = 1'b0;
    logic [31:0] prdt_addr_i = '0;
    logic        prdt_is_call_i = 1'b0;
    logic        prdt_is_ret_i = 1'b0;
    logic        inst_is_rvc_i = 1'b0;

    logic [31:0] dut_pc  [2];
    logic [31:0] dut_top [2];
    logic [2:0]  dut_cnt [2];
    logic        dut_ovf [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_gen_ras u_dut (
        .clk(clk), .rst(rst), .jtag_reset_i(jtag_reset_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .stall_i(stall_i),
        .prdt_taken_i(prdt_taken_i), .prdt_addr_i(prdt_addr_i),
        .prdt_is_call_i(prdt_is_call_i), .prdt_is_ret_i(prdt_is_ret_i),
        .inst_is_rvc_i(inst_is_rvc_i),
        .pc_o(dut_pc[0]), .ras_top_o(dut_top[0]),
        .ras_count_o(dut_cnt[0]), .ras_ovf_o(dut_ovf[0])
    );

    pc_gen_ras #(.C_EXT(1'b0)) u_dut_norvc (
        .clk(clk), .rst(rst), .jtag_reset_i(jtag_reset_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .stall_i(stall_i),
        .prdt_taken_i(prdt_taken_i), .prdt_addr_i(prdt_addr_i),
        .prdt_is_call_i(prdt_is_call_i), .prdt_is_ret_i(prdt_is_ret_i),
        .inst_is_rvc_i(inst_is_rvc_i),
        .pc_o(dut_pc[1]), .ras_top_o(dut_top[1]),
        .ras_count_o(dut_cnt[1]), .ras_ovf_o(dut_ovf[1])
    );

    // Model: stack kept oldest-first in m_stk[k][0..m_cnt-1]; full push drops the oldest.
    logic [31:0] m_pc  [2];
    logic [31:0] m_stk [2][4];
    int          m_cnt [2];
    bit          m_ovf [2];

    task automatic model_step(input int k);
        logic [31:0] st, ra, np;
        if (rst || jtag_reset_i) begin
            m_pc[k] = 32'h0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
        end else if (jump_flag_i) begin
            m_pc[k] = jump_addr_i; m_cnt[k] = 0;
        end else if (!stall_i && hold_flag_i == 3'd0) begin
            st = (k == 0 && inst_is_rvc_i) ? 32'd2 : 32'd4;
            ra = m_pc[k] + st;
            if (prdt_is_ret_i && m_cnt[k] > 0) begin
                np = m_stk[k][m_cnt[k]-1];
                if (prdt_is_call_i) m_stk[k][m_cnt[k]-1] = ra;
                else                m_cnt[k] = m_cnt[k] - 1;
            end else begin
                np = prdt_taken_i ? prdt_addr_i : ra;
                if (prdt_is_call_i) begin
                    if (m_cnt[k] == 4) begin
                        for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
                        m_stk[k][3] = ra;
                        m_ovf[k] = 1'b1;
                    end else begin
                        m_stk[k][m_cnt[k]] = ra;
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            m_pc[k] = np;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pc[%0d]", k), dut_pc[k], m_pc[k]);
                chk($sformatf("top[%0d]", k), dut_top[k],
                    (m_cnt[k] > 0) ? m_stk[k][m_cnt[k]-1] : 32'h0);
                chk($sformatf("count[%0d]", k), 32'(dut_cnt[k]), 32'(m_cnt[k]));
                chk($sformatf("ovf[%0d]", k), 32'(dut_ovf[k]), 32'(m_ovf[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        jump_flag_i = 0; stall_i = 0; hold_flag_i = 0; prdt_taken_i = 0;
        prdt_is_call_i = 0; prdt_is_ret_i = 0; inst_is_rvc_i = 0;
    endtask

    task automatic call_to(input logic [31:0] tgt);
        idle();
        prdt_is_call_i = 1; prdt_taken_i = 1; prdt_addr_i = tgt;
        tick();
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        idle();
        jump_flag_i = 1; jump_addr_i = tgt;
        tick();
    endtask

    initial begin
        tick(); tick();
        chk("rst_pc", dut_pc[0], 32'h0);
        chk("rst_count", 32'(dut_cnt[0]), 32'h0);
        chk("rst_ovf", 32'(dut_ovf[0]), 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick(); chk("seq_4", dut_pc[0], 32'h4);
        tick(); chk("seq_8", dut_pc[0], 32'h8);
        inst_is_rvc_i = 1;
        tick();
        chk("rvc_cext1", dut_pc[0], 32'hA);
        chk("rvc_cext0", dut_pc[1], 32'hC);

        // Realign both instances, then a call/return pair.
        jump_to(32'h10);
        call_to(32'h100);
        chk("call_pc", dut_pc[0], 32'h100);
        chk("call_top", dut_top[0], 32'h14);
        chk("call_count", 32'(dut_cnt[0]), 32'h1);
        idle(); prdt_is_ret_i = 1; prdt_taken_i = 1; prdt_addr_i = 32'h999;
        tick();
        chk("ret_pc", dut_pc[0], 32'h14);
        chk("ret_count", 32'(dut_cnt[0]), 32'h0);

        // Five calls overflow a 4-deep stack.
        for (int i = 0; i < 5; i++) call_to(32'h1000 + 32'h100 * i);
        chk("ovf_count", 32'(dut_cnt[0]), 32'h4);
        chk("ovf_flag", 32'(dut_ovf[0]), 32'h1);
        for (int i = 4; i >= 1; i--) begin
            idle(); prdt_is_ret_i = 1;
            tick();
            chk("ovf_ret", dut_pc[0], 32'h1004 + 32'h100 * (i - 1));
        end
        idle(); prdt_is_ret_i = 1; prdt_taken_i = 1; prdt_addr_i = 32'h2000;
        tick();
        chk("empty_ret_pc", dut_pc[0], 32'h2000);

        // Redirect beats stall and flushes the stack; stall alone freezes everything.
        call_to(32'h3000);
        idle(); stall_i = 1; jump_flag_i = 1; jump_addr_i = 32'h200;
        tick();
        chk("jmp_stall_pc", dut_pc[0], 32'h200);
        chk("jmp_flush", 32'(dut_cnt[0]), 32'h0);
        chk("jmp_keep_ovf", 32'(dut_ovf[0]), 32'h1);
        idle(); stall_i = 1; prdt_is_call_i = 1; prdt_taken_i = 1; prdt_addr_i = 32'h500;
        tick();
        chk("stall_pc", dut_pc[0], 32'h200);
        chk("stall_count", 32'(dut_cnt[0]), 32'h0);
        stall_i = 0; hold_flag_i = 3'd2;
        tick();
        chk("hold_pc", dut_pc[0], 32'h200);

        // Call and return in the same cycle.
        jump_to(32'h3C);
        call_to(32'h80);
        idle(); prdt_is_call_i = 1; prdt_is_ret_i = 1;
        tick();
        chk("cr_pc", dut_pc[0], 32'h40);
        chk("cr_top", dut_top[0], 32'h84);
        chk("cr_count", 32'(dut_cnt[0]), 32'h1);

        // Debug reset overrides a same-cycle redirect and push.
        idle(); jtag_reset_i = 1; jump_flag_i = 1; jump_addr_i = 32'h700; prdt_is_call_i = 1;
        tick();
        chk("jtag_pc", dut_pc[0], 32'h0);
        chk("jtag_count", 32'(dut_cnt[0]), 32'h0);
        chk("jtag_ovf", 32'(dut_ovf[0]), 32'h0);
        jtag_reset_i = 0;

        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            jtag_reset_i   = ($urandom_range(0, 149) == 0);
            jump_flag_i    = ($urandom_range(0, 15) == 0);
            jump_addr_i    = $urandom & 32'hFFFF_FFFE;
            stall_i        = ($urandom_range(0, 7) == 0);
            hold_flag_i    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            prdt_taken_i   = $urandom_range(0, 1);
            prdt_addr_i    = $urandom & 32'hFFFF_FFFE;
            prdt_is_call_i = ($urandom_range(0, 2) == 0);
            prdt_is_ret_i  = ($urandom_range(0, 2) == 0);
            inst_is_rvc_i  = $urandom_range(0, 1);
            tick();
        end
        rst = 0; jtag_reset_i = 0; idle();
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
